// File: rtl/dtmf_pkg.sv
// Shared definitions for the DTMF digit collector: key codes, the key
// validity check and the debounce FSM states.
package dtmf_pkg;

  localparam logic [15:0] TONE_NONE = 16'h0000;

  localparam logic [7:0] KEY_0    = 8'h30;
  localparam logic [7:0] KEY_9    = 8'h39;
  localparam logic [7:0] KEY_STAR = 8'h2A;
  localparam logic [7:0] KEY_HASH = 8'h23;
  localparam logic [7:0] KEY_A    = 8'h41;
  localparam logic [7:0] KEY_D    = 8'h44;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CANDIDATE = 2'd1,
    LATCHED   = 2'd2
  } state_e;

  function automatic logic is_valid_key(input logic [7:0] key);
    return ((key >= KEY_0) && (key <= KEY_9)) ||
           (key == KEY_STAR) || (key == KEY_HASH) ||
           ((key >= KEY_A) && (key <= KEY_D));
  endfunction

endpackage

// File: rtl/digit_fifo.sv
// First-word-fall-through FIFO; the head entry is held in a register so
// rd_data_o is registered and keeps its last value once the FIFO drains.
module digit_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             do_push_s, do_pop_s;

  // Push/pop qualification, occupancy and next head value
  always_comb begin
    do_pop_s  = pop_i && (count_q != '0);
    do_push_s = push_i && ((count_q != CW'(DEPTH)) || do_pop_s);
    rd_ptr_d  = do_pop_s ? (rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d   = count_q;
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + 1'b1;
    end else if (!do_push_s && do_pop_s) begin
      count_d = count_q - 1'b1;
    end else begin
      count_d = count_q;
    end
    rd_data_d = rd_data_q;
    // The new head is the entry being written only when no older entry remains
    if (count_d == '0) begin
      rd_data_d = rd_data_q;
    end else if (do_push_s && (wr_ptr_q == rd_ptr_d)) begin
      rd_data_d = wr_data_i;
    end else begin
      rd_data_d = mem_q[rd_ptr_d];
    end
  end

  // Storage, pointers and head register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));

endmodule

// File: rtl/dtmf_digit_collector.sv
// Debounces per-frame DTMF tone codes and queues each accepted key in a
// FWFT FIFO for the register interface to drain.
module dtmf_digit_collector
  import dtmf_pkg::*;
#(
  parameter int CONFIRM_COUNT = 3,
  parameter int RELEASE_COUNT = 2,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              tone_done,
  input  logic [15:0]                       tone,
  input  logic                              rd_en,
  input  logic                              clear_ovf,
  output logic [7:0]                        rd_data,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              digit_strobe,
  output logic                              overflow
);

  localparam logic [3:0] CONFIRM_C = 4'(CONFIRM_COUNT);
  localparam logic [3:0] RELEASE_C = 4'(RELEASE_COUNT);

  state_e     state_q, state_d;
  logic [7:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rel_q, rel_d;
  logic       tone_done_q;
  logic       digit_strobe_q, overflow_q;
  logic       frame_s, valid_s, match_s;
  logic       accept_s, push_ok_s, fifo_full_s;
  logic [7:0] accept_key_s;

  assign frame_s   = tone_done & ~tone_done_q;
  assign valid_s   = (tone[15:8] == 8'h00) && is_valid_key(tone[7:0]);
  assign match_s   = valid_s && (tone[7:0] == cand_q);
  assign push_ok_s = accept_s && (!fifo_full_s || rd_en);

  // Debounce FSM: next state, counters and key acceptance
  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    rel_d        = rel_q;
    accept_s     = 1'b0;
    accept_key_s = cand_q;
    if (frame_s) begin
      case (state_q)
        IDLE: begin
          if (valid_s) begin
            cand_d = tone[7:0];
            cnt_d  = 4'd1;
            if (CONFIRM_C == 4'd1) begin
              accept_s     = 1'b1;
              accept_key_s = tone[7:0];
              rel_d        = 4'd0;
              state_d      = LATCHED;
            end else begin
              state_d = CANDIDATE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CANDIDATE: begin
          if (match_s) begin
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q + 4'd1) == CONFIRM_C) begin
              accept_s = 1'b1;
              rel_d    = 4'd0;
              state_d  = LATCHED;
            end else begin
              state_d = CANDIDATE;
            end
          end else if (valid_s) begin
            cand_d = tone[7:0];
            cnt_d  = 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
        LATCHED: begin
          if (match_s) begin
            rel_d = 4'd0;
          end else begin
            rel_d = rel_q + 4'd1;
            if ((rel_q + 4'd1) == RELEASE_C) begin
              state_d = IDLE;
            end else begin
              state_d = LATCHED;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM registers, frame edge detector and status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      cand_q         <= 8'h00;
      cnt_q          <= 4'd0;
      rel_q          <= 4'd0;
      tone_done_q    <= 1'b1;
      digit_strobe_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cand_q         <= cand_d;
      cnt_q          <= cnt_d;
      rel_q          <= rel_d;
      tone_done_q    <= tone_done;
      digit_strobe_q <= push_ok_s;
      // A fresh drop wins over a simultaneous clear
      if (accept_s && !push_ok_s) begin
        overflow_q <= 1'b1;
      end else if (clear_ovf) begin
        overflow_q <= 1'b0;
      end else begin
        overflow_q <= overflow_q;
      end
    end
  end

  digit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock_i   (clock),
    .reset_i   (reset),
    .push_i    (accept_s),
    .wr_data_i (accept_key_s),
    .pop_i     (rd_en),
    .rd_data_o (rd_data),
    .empty_o   (empty),
    .full_o    (fifo_full_s),
    .count_o   (count)
  );

  assign full         = fifo_full_s;
  assign digit_strobe = digit_strobe_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_dtmf_digit_collector.sv
// Randomised and directed stimulus against a history-based reference model;
// a negedge monitor consumes expected writes/reads from scoreboard queues.
module tb_dtmf_digit_collector;

  localparam int DEPTH   = 16;
  localparam int CONFIRM = 3;
  localparam int RELEASE = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tone_done = 1'b0;
  logic [15:0] tone = 16'h0000;
  logic        rd_en = 1'b0;
  logic        clear_ovf = 1'b0;
  logic [7:0]  rd_data;
  logic        empty, full, digit_strobe, overflow;
  logic [4:0]  count;

  dtmf_digit_collector #(
    .CONFIRM_COUNT (CONFIRM),
    .RELEASE_COUNT (RELEASE),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tone_done    (tone_done),
    .tone         (tone),
    .rd_en        (rd_en),
    .clear_ovf    (clear_ovf),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .digit_strobe (digit_strobe),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  logic [7:0]  KEYS [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                             8'h38, 8'h39, 8'h2A, 8'h23, 8'h41, 8'h42, 8'h43, 8'h44};
  logic [15:0] POOL [8]  = '{16'h0035, 16'h0035, 16'h0023, 16'h0031,
                             16'h0041, 16'h0000, 16'h0135, 16'h0045};

  // Reference model state
  logic [15:0] m_hist[$];
  logic [7:0]  m_fifo[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  exp_strobe[$];
  bit          m_held, m_prev_done, m_ovf;
  logic [7:0]  m_key, m_last_rd;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit valid_code(input logic [15:0] t);
    bit v = 1'b0;
    if (t[15:8] == 8'h00) begin
      for (int i = 0; i < 16; i++) if (t[7:0] == KEYS[i]) v = 1'b1;
    end
    return v;
  endfunction

  // Key accepted after CONFIRM identical valid frames since the last boundary;
  // released after RELEASE non-matching frames since the key was accepted.
  task automatic model_step(input bit r, input bit td, input logic [15:0] t,
                            input bit rd, input bit clr);
    bit acc, rel, was_full, push;
    int n;
    if (r) begin
      m_hist.delete(); m_fifo.delete(); exp_rd.delete(); exp_strobe.delete();
      m_held = 1'b0; m_prev_done = 1'b1; m_ovf = 1'b0; m_last_rd = 8'h00; m_key = 8'h00;
      return;
    end
    acc = 1'b0;
    if (td && !m_prev_done) begin
      m_hist.push_back(t);
      n = m_hist.size();
      if (!m_held) begin
        if (n >= CONFIRM && valid_code(t)) begin
          acc = 1'b1;
          for (int i = n - CONFIRM; i < n; i++) if (m_hist[i] != t) acc = 1'b0;
          if (acc) begin
            m_held = 1'b1; m_key = t[7:0]; m_hist.delete();
          end
        end
      end else if (n >= RELEASE) begin
        rel = 1'b1;
        for (int i = n - RELEASE; i < n; i++) if (m_hist[i] == {8'h00, m_key}) rel = 1'b0;
        if (rel) begin
          m_held = 1'b0; m_hist.delete();
        end
      end
    end
    m_prev_done = td;
    was_full = (m_fifo.size() == DEPTH);
    push = acc && (!was_full || rd);
    if (rd && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (push) begin
      m_fifo.push_back(m_key); exp_rd.push_back(m_key); exp_strobe.push_back(m_key);
    end
    if (acc && !push) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (m_fifo.size() > 0) m_last_rd = m_fifo[0];
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step(reset, tone_done, tone, rd_en, clear_ovf);
    #1;
    rd_en = 1'b0; clear_ovf = 1'b0; reset = 1'b0;
  endtask

  task automatic frame(input logic [15:0] code, input bit rd_rise, input bit rnd);
    int gap;
    tone = code; tone_done = 1'b1; rd_en = rd_rise;
    cycle();
    tone_done = 1'b0;
    gap = rnd ? $urandom_range(1, 3) : 1;
    for (int g = 0; g < gap; g++) begin
      if (rnd) begin
        rd_en = ($urandom_range(0, 3) == 0);
        clear_ovf = ($urandom_range(0, 15) == 0);
      end
      cycle();
    end
  endtask

  task automatic frames(input logic [15:0] code, input int n);
    for (int i = 0; i < n; i++) frame(code, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n = m_fifo.size() + 1;
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1; cycle();
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (mon_en) begin
      chk("digit_strobe", int'(digit_strobe), int'(exp_strobe.size() > 0));
      if (exp_strobe.size() > 0) void'(exp_strobe.pop_front());
      if (rd_en && !empty) begin
        if (exp_rd.size() == 0) chk("pop_unexpected", 1, 0);
        else chk("rd_data_pop", int'(rd_data), int'(exp_rd.pop_front()));
      end
      chk("count", int'(count), m_fifo.size());
      chk("empty", int'(empty), int'(m_fifo.size() == 0));
      chk("full", int'(full), int'(m_fifo.size() == DEPTH));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("rd_data", int'(rd_data), int'(m_last_rd));
    end
  end

  initial begin
    reset = 1'b1; cycle();
    mon_en = 1'b1;
    reset = 1'b1; cycle();

    // Basic accept
    frames(16'h0035, 3); frames(16'h0000, 2); drain();
    // Flicker then confirmed
    frames(16'h0035, 2); frames(16'h0000, 1); frames(16'h0035, 3);
    frames(16'h0000, 2); drain();
    // Hold with a single gap, release, re-press
    frames(16'h0023, 5); frames(16'h0000, 1); frames(16'h0023, 5);
    frames(16'h0000, 2); frames(16'h0023, 3); frames(16'h0000, 2); drain();
    // Key change while latched
    frames(16'h0031, 3); frames(16'h0032, 3); frames(16'h0032, 3);
    frames(16'h0000, 2); drain();
    // Overflow: 16 to fill, 17th dropped, 18th with simultaneous read
    for (int k = 0; k < 18; k++) begin
      frames({8'h00, KEYS[k % 16]}, 2);
      frame({8'h00, KEYS[k % 16]}, (k == 17), 1'b0);
      frames(16'h0000, 2);
    end
    clear_ovf = 1'b1; cycle();
    drain();
    // Reset discards a partial key
    frames(16'h0037, 2); reset = 1'b1; cycle();
    frames(16'h0037, 2); frames(16'h0000, 2);
    // Held-high tone_done is one frame; reads while empty are ignored
    tone = 16'h0038; tone_done = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    tone_done = 1'b0; cycle();
    frames(16'h0000, 1);
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; cycle();
    end

    // Randomised bursts
    for (int b = 0; b < 250; b++) begin
      logic [15:0] code;
      int reps;
      code = POOL[$urandom_range(0, 7)];
      reps = $urandom_range(1, 5);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1; cycle();
      end
      for (int r = 0; r < reps; r++) frame(code, ($urandom_range(0, 7) == 0), 1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
